// File: rtl/scope_capture_ctrl.sv
// One-shot triggered capture sequencer with pre-trigger history, driving the
// write port of a single-port sample RAM.
module scope_capture_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 12,
    parameter int PRE_DEPTH = 256,
    parameter int AUTO_TO   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_en,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              capture_done,
    output logic [ADDR_W-1:0] start_addr,
    output logic              trig_forced,
    output logic              busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int MAXC  = (DEPTH > AUTO_TO) ? DEPTH : AUTO_TO;
    localparam int CNT_W = $clog2(MAXC + 1);

    localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_DEPTH - 1);
    localparam logic [CNT_W-1:0]  POST_LOAD = CNT_W'(DEPTH - PRE_DEPTH - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'((AUTO_TO == 0) ? 0 : AUTO_TO - 1);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]  post_cnt_q, post_cnt_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic              forced_q, forced_d;

    logic accept, rise, fall, trig_cond, to_hit;

    // POST with an exhausted counter is the one-cycle drain before DONE; nothing is accepted then.
    assign accept = sample_en && ((state_q == S_PRE) || (state_q == S_ARMED) ||
                                  ((state_q == S_POST) && (post_cnt_q != '0)));

    assign rise      = prev_vld_q && (prev_q < trig_level) && (sample_in >= trig_level);
    assign fall      = prev_vld_q && (prev_q > trig_level) && (sample_in <= trig_level);
    assign trig_cond = trig_slope ? fall : rise;
    assign to_hit    = (AUTO_TO != 0) && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        pre_cnt_d  = pre_cnt_q;
        to_cnt_d   = to_cnt_q;
        post_cnt_d = post_cnt_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        start_d    = start_q;
        forced_d   = forced_q;

        if (accept) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = sample_in;
            ptr_d      = ptr_q + ADDR_W'(1);
            prev_d     = sample_in;
            prev_vld_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d    = S_PRE;
                    pre_cnt_d  = '0;
                    to_cnt_d   = '0;
                    forced_d   = 1'b0;
                    prev_vld_d = 1'b0;
                end
            end
            S_PRE: begin
                if (accept) begin
                    pre_cnt_d = pre_cnt_q + CNT_W'(1);
                    if (pre_cnt_q == PRE_LAST) state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (accept) begin
                    to_cnt_d = to_cnt_q + CNT_W'(1);
                    if (trig_cond || to_hit) begin
                        state_d    = S_POST;
                        start_d    = ptr_q - PRE_OFS;
                        post_cnt_d = POST_LOAD;
                        forced_d   = !trig_cond;
                    end
                end
            end
            S_POST: begin
                if (accept) post_cnt_d = post_cnt_q - CNT_W'(1);
                else if (post_cnt_q == '0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort discards the sample accepted this cycle entirely, pointer included.
        if (abort) begin
            state_d    = S_IDLE;
            wr_en_d    = 1'b0;
            ptr_d      = ptr_q;
            prev_d     = prev_q;
            prev_vld_d = prev_vld_q;
            start_d    = start_q;
            forced_d   = forced_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            pre_cnt_q  <= '0;
            to_cnt_q   <= '0;
            post_cnt_q <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            start_q    <= '0;
            forced_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            pre_cnt_q  <= pre_cnt_d;
            to_cnt_q   <= to_cnt_d;
            post_cnt_q <= post_cnt_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            start_q    <= start_d;
            forced_q   <= forced_d;
        end
    end

    assign ram_wr_en    = wr_en_q;
    assign ram_wr_addr  = wr_addr_q;
    assign ram_wr_data  = wr_data_q;
    assign capture_done = (state_q == S_DONE);
    assign busy         = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
    assign start_addr   = start_q;
    assign trig_forced  = forced_q;
endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed bench: table-driven full captures plus hand sequences for
// sparse strobes, abort, arm/abort collision and reset mid-capture.
module tb_scope_capture_ctrl;
    localparam int AW = 4;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst, sample_en, arm, abort, trig_slope;
    logic [DW-1:0] sample_in, trig_level;
    logic          ram_wr_en, capture_done, trig_forced, busy;
    logic [AW-1:0] ram_wr_addr, start_addr;
    logic [DW-1:0] ram_wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    scope_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW), .PRE_DEPTH(4), .AUTO_TO(20)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_en(sample_en),
        .arm(arm), .abort(abort), .trig_level(trig_level), .trig_slope(trig_slope),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .capture_done(capture_done), .start_addr(start_addr),
        .trig_forced(trig_forced), .busy(busy)
    );

    typedef struct {
        logic          rst, arm, abort, en, slope;
        logic [DW-1:0] din, lvl;
        logic          e_wr, e_done, e_busy, e_forced, chk_start;
        logic [AW-1:0] e_addr, e_start;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic ab, input logic en,
                         input int din, input int lvl, input logic sl);
        rst = r; arm = a; abort = ab; sample_en = en;
        sample_in = DW'(din); trig_level = DW'(lvl); trig_slope = sl;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic r, input logic a, input logic en, input int din,
                        input int lvl, input logic sl, input logic ewr, input int ea,
                        input int ed, input logic edone, input logic ebusy,
                        input logic ef, input logic cs, input int es);
        vec_t v;
        v.rst = r; v.arm = a; v.abort = 1'b0; v.en = en; v.slope = sl;
        v.din = DW'(din); v.lvl = DW'(lvl);
        v.e_wr = ewr; v.e_addr = AW'(ea); v.e_data = DW'(ed);
        v.e_done = edone; v.e_busy = ebusy; v.e_forced = ef;
        v.chk_start = cs; v.e_start = AW'(es);
        tbl.push_back(v);
    endtask

    function automatic int sval(input int mode, input int k);
        case (mode)
            0:       return k;
            1:       return (k <= 15) ? 15 - k : 0;
            default: return 3;
        endcase
    endfunction

    // tk = hand-derived index of the triggering sample; 11 post samples follow it.
    task automatic add_capture(input int mode, input int lvl, input logic sl,
                               input int tk, input logic f, input int st);
        int last;
        last = tk + 11;
        push(1, 0, 0, 0, lvl, sl, 0, 0, 0, 0, 0, 0, 1, 0);
        push(0, 1, 0, 0, lvl, sl, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k <= last; k++)
            push(0, 0, 1, sval(mode, k), lvl, sl, 1, k % 16, sval(mode, k),
                 0, 1, (k >= tk) ? f : 1'b0, 0, 0);
        push(0, 0, 1, sval(mode, last + 1), lvl, sl, 0, 0, 0, 1, 0, f, 1, st);
        push(0, 0, 1, sval(mode, last + 2), lvl, sl, 0, 0, 0, 1, 0, f, 1, st);
    endtask

    initial begin
        int writes;
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("reset.wr_en", ram_wr_en, 0);
        chk("reset.busy", busy, 0);
        chk("reset.done", capture_done, 0);

        add_capture(0, 9, 0, 9, 0, 5);    // rising ramp, trigger on 9 at addr 9
        add_capture(1, 5, 1, 10, 0, 6);   // falling 15..0, trigger on 5 at addr 10
        add_capture(2, 100, 0, 23, 1, 3); // constant 3, forced on 20th armed sample

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].arm, tbl[i].abort, tbl[i].en,
                  int'(tbl[i].din), int'(tbl[i].lvl), tbl[i].slope);
            chk($sformatf("row%0d.wr_en", i), ram_wr_en, tbl[i].e_wr);
            if (tbl[i].e_wr || tbl[i].rst) begin
                chk($sformatf("row%0d.addr", i), ram_wr_addr, tbl[i].e_addr);
                chk($sformatf("row%0d.data", i), ram_wr_data, tbl[i].e_data);
            end
            chk($sformatf("row%0d.done", i), capture_done, tbl[i].e_done);
            chk($sformatf("row%0d.busy", i), busy, tbl[i].e_busy);
            chk($sformatf("row%0d.forced", i), trig_forced, tbl[i].e_forced);
            if (tbl[i].chk_start)
                chk($sformatf("row%0d.start", i), start_addr, tbl[i].e_start);
        end

        // Reset mid-ARMED, coming from the DONE left by the auto-trigger capture.
        drive(0, 1, 0, 0, 0, 100, 0);
        for (int k = 0; k < 6; k++) drive(0, 0, 0, 1, 50, 100, 0);
        chk("armed.busy", busy, 1);
        drive(1, 0, 0, 1, 50, 100, 0);
        chk("rstmid.wr_en", ram_wr_en, 0);
        chk("rstmid.addr", ram_wr_addr, 0);
        chk("rstmid.data", ram_wr_data, 0);
        chk("rstmid.busy", busy, 0);
        chk("rstmid.done", capture_done, 0);
        chk("rstmid.forced", trig_forced, 0);
        chk("rstmid.start", start_addr, 0);

        // Sparse strobes: one strobe then two idle cycles, ramp values.
        drive(0, 1, 0, 0, 0, 9, 0);
        writes = 0;
        for (int v = 0; v < 21; v++) begin
            drive(0, 0, 0, 1, v, 9, 0);
            if (ram_wr_en) writes++;
            chk($sformatf("sparse%0d.wr_en", v), ram_wr_en, 1);
            chk($sformatf("sparse%0d.data", v), ram_wr_data, v);
            chk($sformatf("sparse%0d.addr", v), ram_wr_addr, v % 16);
            for (int j = 0; j < 2; j++) begin
                drive(0, 0, 0, 0, 99, 9, 0);
                if (ram_wr_en) writes++;
                chk($sformatf("sparse%0d.idle%0d", v, j), ram_wr_en, 0);
            end
        end
        chk("sparse.writes", writes, 21);
        chk("sparse.done", capture_done, 1);
        chk("sparse.start", start_addr, 5);

        // Arm and abort together in DONE: abort wins.
        drive(0, 1, 1, 1, 7, 9, 0);
        chk("armabort.done", capture_done, 0);
        chk("armabort.busy", busy, 0);
        chk("armabort.wr_en", ram_wr_en, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 8, 9, 0);
            chk($sformatf("armabort.idle%0d.wr_en", k), ram_wr_en, 0);
            chk($sformatf("armabort.idle%0d.busy", k), busy, 0);
        end

        // Abort after 5 POST writes; the aborted sample must not advance the pointer.
        drive(1, 0, 0, 0, 0, 9, 0);
        drive(0, 1, 0, 0, 0, 9, 0);
        for (int k = 0; k < 15; k++) drive(0, 0, 0, 1, k, 9, 0);
        chk("abpost.addr14", ram_wr_addr, 14);
        chk("abpost.busy", busy, 1);
        drive(0, 0, 1, 1, 15, 9, 0);
        chk("abpost.wr_en", ram_wr_en, 0);
        chk("abpost.busy_off", busy, 0);
        chk("abpost.done", capture_done, 0);
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 1, 16 + k, 9, 0);
            chk($sformatf("abpost.idle%0d", k), ram_wr_en, 0);
        end
        drive(0, 1, 0, 0, 0, 9, 0);
        chk("rearm.busy", busy, 1);
        drive(0, 0, 0, 1, 100, 9, 0);
        chk("rearm.wr_en", ram_wr_en, 1);
        chk("rearm.addr", ram_wr_addr, 15);
        chk("rearm.data", ram_wr_data, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/scope_capture_ctrl.md
Name: scope_capture_ctrl

Overview:
Capture sequencer for the simple oscilloscope. It sits between the ADC/waveform sample stream and the 1-port sample RAM, and drives the RAM write port. Each capture is one-shot and triggered, with a pre-trigger window: it arms, fills the pre-trigger history, waits for a level crossing (or an auto-trigger timeout), writes the post-trigger samples, then freezes the RAM. While frozen, the display side reads the RAM starting at the reported start address.

Parameters:
ADDR_W, 10, RAM address width; capture depth DEPTH = 2^ADDR_W.
DATA_W, 12, sample width.
PRE_DEPTH, 256, samples kept before the trigger; legal range 1..DEPTH-2.
AUTO_TO, 4096, accepted samples in ARMED before a forced trigger; 0 disables auto-trigger.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
sample_in  in  DATA_W  unsigned sample from the waveform/ADC path.
sample_en  in  1  qualifies sample_in for one cycle (decimation strobe).
arm  in  1  pulse; starts a capture from IDLE or DONE.
abort  in  1  pulse; returns to IDLE from any state.
trig_level  in  DATA_W  unsigned trigger threshold.
trig_slope  in  1  0 = rising crossing, 1 = falling crossing.
ram_wr_en  out  1  RAM write strobe.
ram_wr_addr  out  ADDR_W  RAM write address.
ram_wr_data  out  DATA_W  RAM write data.
capture_done  out  1  high in DONE; RAM contents are stable.
start_addr  out  ADDR_W  address of the oldest sample of the completed capture.
trig_forced  out  1  the last capture was auto-triggered.
busy  out  1  high in PRE, ARMED, POST.

Behaviour:
- Reset (rst high at a clk edge): state = IDLE. All outputs are 0. Internal counters and the previous-sample register are cleared.
- Write path:
  - On each sample_en accepted in PRE, ARMED or POST, the next cycle drives ram_wr_en = 1 for exactly one cycle, with ram_wr_data = sample_in and ram_wr_addr = the write pointer.
  - The pointer then increments modulo DEPTH.
  - Latency is 1 cycle from sample_en to the write.
  - No write ever occurs in IDLE or DONE.
- States:
  - IDLE: on arm, go to PRE. The write pointer is kept (not reset); the pre counter and timeout counter are cleared; trig_forced is cleared.
  - PRE: write every accepted sample. After the PRE_DEPTH-th write is issued, go to ARMED. Triggers are ignored in PRE.
  - ARMED: keep writing every accepted sample into the circular buffer.
    - The trigger condition is evaluated on each accepted sample, against the previous accepted sample.
    - Rising: prev < trig_level and sample_in >= trig_level. Falling: prev > trig_level and sample_in <= trig_level.
    - The first sample of a capture has no valid prev and cannot trigger.
    - On trigger, the triggering sample is written at trig_addr. start_addr is set to (trig_addr − PRE_DEPTH) mod DEPTH. The post counter is loaded with DEPTH − PRE_DEPTH − 1, and the state goes to POST.
    - If AUTO_TO ≠ 0 and AUTO_TO accepted samples pass without a trigger, the AUTO_TO-th sample is treated as the trigger and trig_forced is set to 1.
  - POST: write each accepted sample and decrement the post counter. When it reaches 0 after the last write, go to DONE. If the post counter is 0 on entry, go to DONE immediately after the trigger write.
  - DONE: capture_done = 1 and start_addr is held. On arm, go to PRE with the same clears as from IDLE; capture_done drops on the next cycle.
- busy = 1 exactly in PRE, ARMED and POST.
- Abort: takes effect at the next clk edge in any state. The state goes to IDLE; capture_done, busy and ram_wr_en go to 0. A write already scheduled for that edge is suppressed.
- Priorities: rst > abort > arm. An arm pulse outside IDLE/DONE is ignored.
- trig_level and trig_slope are sampled at each evaluation and need not be static.
- A change of trig_level mid-capture takes effect on the next accepted sample.
- Arithmetic: all comparisons are unsigned. Address arithmetic wraps mod 2^ADDR_W. Counters are wide enough for max(DEPTH, AUTO_TO) without overflow.

Test Plan:
Benches use ADDR_W=4 (DEPTH=16), PRE_DEPTH=4, AUTO_TO=20, with sample_en high every cycle unless noted.

- Ramp trigger: arm at t0; sample_in = 0,1,2,…, trig_level=9, trig_slope=0.
  - Expect 4 PRE writes at addresses 0–3.
  - Trigger on value 9 written at address 9; start_addr = 5.
  - 11 further writes, wrapping through address 15 to 0–4.
  - capture_done rises one cycle after the write of value 20; trig_forced = 0.
- Falling slope: sample_in = 15 down to 0, trig_level=5, trig_slope=1 -> trigger sample = 5; no trigger on values above 5.
- Auto trigger: constant sample_in=3, trig_level=100 -> after 4 PRE writes plus 20 ARMED samples, a forced trigger with trig_forced = 1; exactly 16 − 4 − 1 = 11 POST writes follow; then DONE.
- Sparse strobes: sample_en every 3rd cycle.
  - Each write occurs exactly 1 cycle after its strobe.
  - No writes on non-strobe cycles.
  - The total write count for one capture equals the count in the ramp test.
- Abort mid-POST: abort after 5 POST writes -> next cycle busy = 0 with no further ram_wr_en; state is IDLE; a subsequent arm starts PRE at the next pointer value.
- Arm and abort in the same cycle while in DONE -> IDLE, no writes; rst asserted mid-ARMED -> all outputs 0 on the next edge.
